// File: rtl/titan_fetch_ctrl.sv
// Instruction-fetch sequencer: one Wishbone-classic read per PC, holds the
// result at the IF/ID boundary and stalls the PC register until it is consumed.
module titan_fetch_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INST       = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        pipe_stall_i,
    input  logic        flush_i,
    output logic [31:0] iport_addr_o,
    output logic        iport_cyc_o,
    output logic        iport_stb_o,
    input  logic [31:0] iport_dat_i,
    input  logic        iport_ack_i,
    input  logic        iport_err_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        inst_fault_o,
    output logic        fetch_stall_o,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] LAST_CNT = TIMEOUT_CYCLES - 1;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] cnt_q, cnt_d;
    logic        cyc_q, cyc_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic        timeout;
    logic        resp;

    // Bus handshake: cyc/stb rise together with a stable address and stay
    // high until ack, err or timeout is seen; they fall on that same edge.
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST_CNT);
    assign resp    = iport_ack_i | iport_err_i | timeout;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        valid_d = valid_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (!flush_i) begin
                    if (pc_i[1:0] != 2'b00) begin
                        // Misaligned: no bus access, the IF stage raises the trap.
                        inst_d  = NOP_INST;
                        valid_d = 1'b1;
                        fault_d = 1'b0;
                        state_d = HOLD;
                    end else begin
                        addr_d  = pc_i;
                        cyc_d   = 1'b1;
                        cnt_d   = 32'd0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 32'd1;
                if (flush_i) begin
                    if (resp) begin
                        cyc_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (iport_err_i) begin
                    cyc_d   = 1'b0;
                    inst_d  = NOP_INST;
                    valid_d = 1'b1;
                    fault_d = 1'b1;
                    state_d = HOLD;
                end else if (iport_ack_i) begin
                    cyc_d   = 1'b0;
                    inst_d  = iport_dat_i;
                    valid_d = 1'b1;
                    fault_d = 1'b0;
                    state_d = HOLD;
                end else if (timeout) begin
                    cyc_d   = 1'b0;
                    inst_d  = NOP_INST;
                    valid_d = 1'b1;
                    fault_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (flush_i || !pipe_stall_i) begin
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                    fault_d = 1'b0;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // The flushed transfer must still finish before cyc may drop.
                cnt_d = cnt_q + 32'd1;
                if (resp) begin
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            inst_q  <= NOP_INST;
            cnt_q   <= 32'd0;
            cyc_q   <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign iport_addr_o  = addr_q;
    assign iport_cyc_o   = cyc_q;
    assign iport_stb_o   = cyc_q;
    assign inst_o        = inst_q;
    assign inst_valid_o  = valid_q;
    assign inst_fault_o  = fault_q;
    assign fetch_stall_o = (state_q != HOLD) | pipe_stall_i;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_titan_fetch_ctrl.sv
// Directed bench for titan_fetch_ctrl: two instances (default and short timeout)
// checked every cycle against a transaction-level model, plus literal checks.
module tb_titan_fetch_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam int unsigned TO_A = 255;
    localparam int unsigned TO_B = 4;

    // clock / reset and driven inputs
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = 32'd0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] dat = 32'd0;
    logic        ack = 1'b0;
    logic        err = 1'b0;

    always #5 clk = ~clk;

    logic [31:0] o_addr [2];
    logic        o_cyc [2];
    logic        o_stb [2];
    logic [31:0] o_inst [2];
    logic        o_valid [2];
    logic        o_fault [2];
    logic        o_fstall [2];
    logic [1:0]  o_state [2];

    titan_fetch_ctrl #(.TIMEOUT_CYCLES(TO_A), .NOP_INST(NOP)) dut (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .pipe_stall_i(stall), .flush_i(flush),
        .iport_addr_o(o_addr[0]), .iport_cyc_o(o_cyc[0]), .iport_stb_o(o_stb[0]),
        .iport_dat_i(dat), .iport_ack_i(ack), .iport_err_i(err),
        .inst_o(o_inst[0]), .inst_valid_o(o_valid[0]), .inst_fault_o(o_fault[0]),
        .fetch_stall_o(o_fstall[0]), .dbg_state(o_state[0])
    );

    titan_fetch_ctrl #(.TIMEOUT_CYCLES(TO_B), .NOP_INST(NOP)) dut_to (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .pipe_stall_i(stall), .flush_i(flush),
        .iport_addr_o(o_addr[1]), .iport_cyc_o(o_cyc[1]), .iport_stb_o(o_stb[1]),
        .iport_dat_i(dat), .iport_ack_i(ack), .iport_err_i(err),
        .inst_o(o_inst[1]), .inst_valid_o(o_valid[1]), .inst_fault_o(o_fault[1]),
        .fetch_stall_o(o_fstall[1]), .dbg_state(o_state[1])
    );

    // scoreboard counters
    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // model: an open bus transaction, whether its result is to be thrown
    // away, how long it has waited, and the result currently offered to IF
    logic        m_busy [2];
    logic        m_doomed [2];
    int unsigned m_waited [2];
    logic [31:0] m_addr [2];
    logic        m_valid [2];
    logic        m_fault [2];
    logic [31:0] m_inst [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int unsigned lim;
            bit          resp;
            lim = (k == 0) ? TO_A : TO_B;
            if (!rst) begin
                m_busy[k] = 1'b0; m_doomed[k] = 1'b0; m_waited[k] = 0;
                m_addr[k] = 32'd0; m_valid[k] = 1'b0; m_fault[k] = 1'b0; m_inst[k] = NOP;
            end else if (m_busy[k]) begin
                resp = ack || err || (lim != 0 && m_waited[k] == lim - 1);
                if (m_doomed[k] || flush) begin
                    if (resp) begin
                        m_busy[k] = 1'b0;
                        m_doomed[k] = 1'b0;
                    end else begin
                        m_doomed[k] = 1'b1;
                        m_waited[k]++;
                    end
                end else if (resp) begin
                    m_busy[k]  = 1'b0;
                    m_valid[k] = 1'b1;
                    m_fault[k] = err || !ack;
                    m_inst[k]  = m_fault[k] ? NOP : dat;
                end else begin
                    m_waited[k]++;
                end
            end else if (m_valid[k]) begin
                if (flush || !stall) begin
                    m_valid[k] = 1'b0; m_fault[k] = 1'b0; m_inst[k] = NOP;
                end
            end else if (!flush) begin
                if (pc[1:0] != 2'b00) begin
                    m_valid[k] = 1'b1; m_fault[k] = 1'b0; m_inst[k] = NOP;
                end else begin
                    m_busy[k] = 1'b1; m_addr[k] = pc; m_waited[k] = 0;
                end
            end
        end
    endtask

    // compare process: every cycle, both instances, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("u%0d.cyc", k), 32'(o_cyc[k]), 32'(m_busy[k]));
                check($sformatf("u%0d.stb", k), 32'(o_stb[k]), 32'(m_busy[k]));
                check($sformatf("u%0d.addr", k), o_addr[k], m_addr[k]);
                check($sformatf("u%0d.inst", k), o_inst[k], m_inst[k]);
                check($sformatf("u%0d.valid", k), 32'(o_valid[k]), 32'(m_valid[k]));
                check($sformatf("u%0d.fault", k), 32'(o_fault[k]), 32'(m_fault[k]));
                check($sformatf("u%0d.fstall", k), 32'(o_fstall[k]), 32'(!m_valid[k] || stall));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; ack = 1'b0; err = 1'b0; flush = 1'b0; stall = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // reset values
        do_reset();
        chk_en = 1'b1;
        check("rst.cyc", 32'(o_cyc[0]), 32'd0);
        check("rst.addr", o_addr[0], 32'd0);
        check("rst.inst", o_inst[0], NOP);
        check("rst.valid", 32'(o_valid[0]), 32'd0);
        check("rst.fault", 32'(o_fault[0]), 32'd0);
        check("rst.fstall", 32'(o_fstall[0]), 32'd1);

        // zero-wait fetch
        pc = 32'h0;
        tick();
        check("zw.cyc", 32'(o_cyc[0]), 32'd1);
        check("zw.addr", o_addr[0], 32'h0);
        ack = 1'b1; dat = 32'h0010_0093;
        tick();
        ack = 1'b0;
        check("zw.inst", o_inst[0], 32'h0010_0093);
        check("zw.valid", 32'(o_valid[0]), 32'd1);
        check("zw.cyc_drop", 32'(o_cyc[0]), 32'd0);
        check("zw.fstall", 32'(o_fstall[0]), 32'd0);
        tick();
        check("zw.advance_valid", 32'(o_valid[0]), 32'd0);
        pc = 32'h4;
        tick();
        check("zw.next_cyc", 32'(o_cyc[0]), 32'd1);
        check("zw.next_addr", o_addr[0], 32'h4);

        // wait states then downstream stall
        do_reset();
        pc = 32'h100;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("ws.stb", 32'(o_stb[0]), 32'd1);
            check("ws.fstall", 32'(o_fstall[0]), 32'd1);
            tick();
        end
        check("ws.stb5", 32'(o_stb[0]), 32'd1);
        ack = 1'b1; dat = 32'h00A0_0113;
        tick();
        ack = 1'b0; stall = 1'b1;
        #1;
        check("ws.inst", o_inst[0], 32'h00A0_0113);
        check("ws.cyc_drop", 32'(o_cyc[0]), 32'd0);
        check("ws.hold_fstall", 32'(o_fstall[0]), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("ws.hold_inst", o_inst[0], 32'h00A0_0113);
            check("ws.hold_valid", 32'(o_valid[0]), 32'd1);
        end
        stall = 1'b0;
        #1;
        check("ws.release_fstall", 32'(o_fstall[0]), 32'd0);
        tick();
        check("ws.consumed", 32'(o_valid[0]), 32'd0);

        // err together with ack
        do_reset();
        pc = 32'h200;
        tick();
        check("err.addr", o_addr[0], 32'h200);
        ack = 1'b1; err = 1'b1; dat = 32'h1234_5678;
        tick();
        ack = 1'b0; err = 1'b0; stall = 1'b1;
        check("err.inst", o_inst[0], NOP);
        check("err.fault", 32'(o_fault[0]), 32'd1);
        check("err.valid", 32'(o_valid[0]), 32'd1);
        check("err.cyc", 32'(o_cyc[0]), 32'd0);

        // timeout on the short-timeout instance
        do_reset();
        pc = 32'h300;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("to.cyc_high", 32'(o_cyc[1]), 32'd1);
            tick();
        end
        check("to.cyc_low", 32'(o_cyc[1]), 32'd0);
        check("to.fault", 32'(o_fault[1]), 32'd1);
        check("to.valid", 32'(o_valid[1]), 32'd1);
        check("to.inst", o_inst[1], NOP);
        check("to.long_still_waiting", 32'(o_cyc[0]), 32'd1);

        // flush during REQ, response arrives later and is dropped
        do_reset();
        pc = 32'h400;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; pc = 32'h800;
        for (int i = 0; i < 2; i++) begin
            check("fl.drain_cyc", 32'(o_cyc[0]), 32'd1);
            check("fl.drain_valid", 32'(o_valid[0]), 32'd0);
            tick();
        end
        check("fl.drain_cyc3", 32'(o_cyc[0]), 32'd1);
        ack = 1'b1; dat = 32'hDEAD_BEEF;
        tick();
        ack = 1'b0;
        check("fl.done_cyc", 32'(o_cyc[0]), 32'd0);
        check("fl.done_valid", 32'(o_valid[0]), 32'd0);
        check("fl.done_inst", o_inst[0], NOP);
        tick();
        check("fl.redirect_addr", o_addr[0], 32'h800);
        check("fl.redirect_cyc", 32'(o_cyc[0]), 32'd1);
        ack = 1'b1; dat = 32'h0020_0193;
        tick();
        ack = 1'b0; stall = 1'b1;
        check("fl.redirect_inst", o_inst[0], 32'h0020_0193);

        // flush with ack on the same edge
        do_reset();
        pc = 32'h500;
        tick();
        flush = 1'b1; ack = 1'b1; dat = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0; ack = 1'b0;
        check("fa.cyc", 32'(o_cyc[0]), 32'd0);
        check("fa.valid", 32'(o_valid[0]), 32'd0);
        tick();
        check("fa.reissue", o_addr[0], 32'h500);

        // misaligned PC, then reset in the middle of a transfer
        do_reset();
        pc = 32'h2;
        tick();
        check("mis.cyc", 32'(o_cyc[0]), 32'd0);
        check("mis.valid", 32'(o_valid[0]), 32'd1);
        check("mis.fault", 32'(o_fault[0]), 32'd0);
        check("mis.inst", o_inst[0], NOP);
        tick();
        pc = 32'h600;
        tick();
        check("mr.cyc", 32'(o_cyc[0]), 32'd1);
        rst = 1'b0;
        tick();
        check("mr.cyc_drop", 32'(o_cyc[0]), 32'd0);
        check("mr.addr", o_addr[0], 32'd0);
        check("mr.inst", o_inst[0], NOP);
        check("mr.valid", 32'(o_valid[0]), 32'd0);
        rst = 1'b1; ack = 1'b1; dat = 32'hDEAD_BEEF;
        tick();
        ack = 1'b0;
        check("mr.late_ack_valid", 32'(o_valid[0]), 32'd0);
        check("mr.new_req", 32'(o_cyc[0]), 32'd1);

        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/titan_fetch_ctrl.md
Name: titan_fetch_ctrl

Overview:
- Instruction-fetch sequencer between the IF stage and the instruction bus port (Wishbone-classic style cyc/stb/ack/err).
- Issues one bus read per PC, holds the returned word for the IF/ID boundary, and drives the IF stall.
- Reports bus errors and timeouts as instruction access faults.
- Discards in-flight responses on flush without violating the bus protocol.

Parameters:
- TIMEOUT_CYCLES, 255: cycles waited for ack/err before declaring an access fault; 0 disables the timeout.
- NOP_INST, 32'h0000_0013: word driven on inst_o when no valid instruction is held, or on fault.

Ports:
- clk_i, input, 1: clock, rising edge.
- rst_i, input, 1: reset, synchronous, active-low.
- pc_i, input, 32: current PC from the IF stage PC register.
- pipe_stall_i, input, 1: downstream pipeline stall request.
- flush_i, input, 1: pipeline flush (branch, jump or exception redirect).
- iport_addr_o, output, 32: instruction bus address.
- iport_cyc_o, output, 1: bus cycle active.
- iport_stb_o, output, 1: bus strobe.
- iport_dat_i, input, 32: bus read data.
- iport_ack_i, input, 1: bus acknowledge.
- iport_err_i, input, 1: bus error.
- inst_o, output, 32: fetched instruction to IF stage.
- inst_valid_o, output, 1: inst_o holds a valid fetch result for pc_i.
- inst_fault_o, output, 1: access fault for the held result; feeds the IF access-fault input.
- fetch_stall_o, output, 1: stall to the PC register.

Behaviour:
- Reset (rst_i=0 at a clock edge) is synchronous and dominates all other inputs. Reset values:
  - state=IDLE
  - iport_cyc_o=iport_stb_o=0
  - iport_addr_o=0
  - inst_o=NOP_INST
  - inst_valid_o=0
  - inst_fault_o=0
  - timeout counter=0
- Reset asserted mid-transfer drops cyc/stb at that edge; a late ack/err is ignored.
- All outputs except fetch_stall_o are registered. fetch_stall_o = (state!=HOLD) | pipe_stall_i, combinational.
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE:
  - flush_i=1: stay in IDLE.
  - pc_i[1:0]!=0: no bus access. Go to HOLD with inst_o=NOP_INST, valid=1, fault=0; the misaligned trap is flagged by the IF stage.
  - Otherwise: iport_addr_o<=pc_i, cyc=stb=1, counter cleared, go to REQ.
- REQ:
  - cyc/stb/addr are held stable.
  - Counter increments each cycle.
  - flush_i=1:
    - If ack/err arrives the same cycle, drop cyc/stb and go to IDLE, discarding the data.
    - Otherwise go to DRAIN.
  - iport_err_i=1 (err wins over a simultaneous ack): inst_o=NOP_INST, fault=1, valid=1, go to HOLD.
  - iport_ack_i=1: inst_o=iport_dat_i, fault=0, valid=1, go to HOLD.
  - Timeout (TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 with no response): same result as err.
  - Any exit from REQ drops cyc/stb on the same edge.
- HOLD:
  - inst_o/valid/fault are held.
  - flush_i=1: valid=0, fault=0, inst_o=NOP_INST, go to IDLE.
  - pipe_stall_i=0: the PC register advances this edge (fetch_stall_o=0). Clear valid/fault, set inst_o=NOP_INST, go to IDLE; the next fetch uses the updated pc_i.
  - pipe_stall_i=1: stay in HOLD.
- DRAIN:
  - cyc/stb stay asserted; the counter keeps running; valid=0; fetch_stall_o=1.
  - On ack, err or timeout: drop cyc/stb, discard the data, go to IDLE.
  - flush_i in DRAIN has no further effect.
- Throughput and latency:
  - Minimum 3 cycles per instruction: IDLE, REQ with zero-wait ack, HOLD.
  - Ack latency N adds N cycles.
- Only one outstanding bus transaction at any time. stb never deasserts before ack, err or timeout.

Test Plan:
- Zero-wait fetch: release reset with pc_i=0x0000_0000, memory acks in the first REQ cycle with 0x0010_0093 -> addr=0; inst_o=0x0010_0093 and valid=1 two cycles after IDLE; fetch_stall_o=0 in HOLD; next request at pc_i=0x4.
- Wait states plus stall: ack after 5 cycles, pipe_stall_i=1 for 3 HOLD cycles -> stb held 5 cycles; fetch_stall_o=1 throughout; inst_o stable in HOLD; advance on the first cycle with pipe_stall_i=0.
- Bus error: err_i with ack_i both asserted -> inst_o=0x0000_0013, inst_fault_o=1, valid=1, cyc dropped the same edge.
- Timeout: TIMEOUT_CYCLES=4, no response -> cyc/stb high for exactly 4 cycles, then fault=1, valid=1.
- Flush during REQ: flush_i pulse at cycle 1, ack 3 cycles later carrying 0xDEAD_BEEF -> DRAIN keeps cyc high until ack; valid never asserts; the data is discarded; a new request goes out at the redirected pc_i.
- Misaligned PC plus mid-transfer reset: pc_i=0x0000_0002 -> no cyc, HOLD with NOP and fault=0. Separately, rst_i=0 during REQ -> cyc=0 next edge and all outputs at reset values.
